// File: rtl/cache_mem_ctrl_if.sv
// Cache-side bus between the dcache/icache and the memory controller.
// The caches drive requests; the controller answers with wait/load.
interface cache_mem_ctrl_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr,
    input  dwait, dload, iwait, iload
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr,
    output dwait, dload, iwait, iload
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for the cache bus: word-addressed backing store with a
// programmable access latency; data requests win over instruction requests.
module cache_mem_ctrl #(
  parameter int LAT = 2,
  parameter int AW  = 10
) (
  input logic             CLK,
  input logic             RST,
  cache_mem_ctrl_if.slave bus
);
  typedef enum logic { IDLE, ACCESS } state_t;
  typedef enum logic { RD, WR } op_t;
  typedef enum logic { OWN_D, OWN_I } owner_t;

  // Any nonzero latency spends one extra settle cycle in ACCESS, so a held
  // request completes LAT+2 cycles after capture; LAT=0 completes in the
  // first ACCESS cycle. Nine bits keep LAT=255 representable.
  localparam logic [8:0] CNT_INIT = (LAT == 0) ? 9'd0 : 9'(LAT + 1);

  logic [31:0]   mem [2**AW];

  state_t        state, state_nxt;
  owner_t        owner;
  op_t           op;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [8:0]    cnt;

  logic [AW-1:0] didx, iidx;
  logic          d_req, still_ok, done;
  logic          unused_addr_bits;

  assign didx  = bus.daddr[AW+1:2];
  assign iidx  = bus.iaddr[AW+1:2];
  assign d_req = bus.dREN | bus.dWEN;
  assign unused_addr_bits = ^{bus.daddr[31:AW+2], bus.daddr[1:0],
                              bus.iaddr[31:AW+2], bus.iaddr[1:0]};

  // The owner must keep presenting the identical request; anything else aborts.
  always_comb begin
    still_ok = 1'b0;
    if (owner == OWN_D)
      still_ok = d_req && (op_t'(bus.dWEN) == op) && (didx == idx);
    else
      still_ok = bus.iREN && (iidx == idx);
  end

  assign done = (state == ACCESS) && still_ok && (cnt == 9'd0);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_req || bus.iREN) state_nxt = ACCESS;
      ACCESS:  if (!still_ok || cnt == 9'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.dwait = 1'b1;
    bus.iwait = 1'b1;
    bus.dload = 32'd0;
    bus.iload = 32'd0;
    if (done) begin
      if (owner == OWN_D) begin
        bus.dwait = 1'b0;
        if (op == RD) bus.dload = mem[idx];
      end else begin
        bus.iwait = 1'b0;
        bus.iload = mem[idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt   <= 9'd0;
      owner <= OWN_D;
    end else if (state == IDLE) begin
      cnt <= CNT_INIT;
      if (d_req)          owner <= OWN_D;
      else if (bus.iREN)  owner <= OWN_I;
    end else if (still_ok && cnt != 9'd0) begin
      cnt <= cnt - 9'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      if (d_req) begin
        idx   <= didx;
        op    <= op_t'(bus.dWEN);
        wdata <= bus.dstore;
      end else if (bus.iREN) begin
        idx <= iidx;
      end
    end
  end

  // A write lands at the end of its completion cycle unless reset cuts it off.
  always_ff @(posedge CLK) begin
    if (!RST && done && owner == OWN_D && op == WR) mem[idx] <= wdata;
  end
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench: four controllers with LAT = 0..3, a word-array model of
// each store and per-instance monitors that check every completion cycle.
module tb_cache_mem_ctrl;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst    [NI];
  logic        dren   [NI];
  logic        dwen   [NI];
  logic        iren   [NI];
  logic [31:0] daddr  [NI];
  logic [31:0] dstore [NI];
  logic [31:0] iaddr  [NI];
  logic        dwait  [NI];
  logic        iwait  [NI];
  logic [31:0] dload  [NI];
  logic [31:0] iload  [NI];

  logic [31:0] mm [NI][1024];

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          rd;
  } exp_t;

  exp_t dq [NI][$];
  exp_t iq [NI][$];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cache_mem_ctrl_if bus ();
    assign bus.dREN   = dren[g];
    assign bus.dWEN   = dwen[g];
    assign bus.daddr  = daddr[g];
    assign bus.dstore = dstore[g];
    assign bus.iREN   = iren[g];
    assign bus.iaddr  = iaddr[g];
    assign dwait[g]   = bus.dwait;
    assign iwait[g]   = bus.iwait;
    assign dload[g]   = bus.dload;
    assign iload[g]   = bus.iload;

    cache_mem_ctrl #(.LAT(g), .AW(10)) u_dut (
      .CLK (clk),
      .RST (rst[g]),
      .bus (bus)
    );

    initial begin
      for (int a = 0; a < 1024; a++) begin
        mm[g][a] = $urandom;
        u_dut.mem[a] = mm[g][a];
      end
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst[g]) begin
        if (dq[g].size() != 0) begin
          chk(dq[g][0].cyc >= cyc, "d_missed", 32'(cyc), 32'(dq[g][0].cyc));
          if (dq[g][0].cyc < cyc) e = dq[g].pop_front();
        end
        if (iq[g].size() != 0) begin
          chk(iq[g][0].cyc >= cyc, "i_missed", 32'(cyc), 32'(iq[g][0].cyc));
          if (iq[g][0].cyc < cyc) e = iq[g].pop_front();
        end
        if (dwait[g] === 1'b0) begin
          chk(dq[g].size() != 0, "d_unexpected_done", 32'(cyc), 32'd0);
          if (dq[g].size() != 0) begin
            e = dq[g].pop_front();
            chk(e.cyc == cyc, "d_done_cycle", 32'(cyc), 32'(e.cyc));
            if (e.rd) chk(dload[g] === e.data, "dload", dload[g], e.data);
          end
        end else begin
          chk(dwait[g] === 1'b1 && dload[g] === 32'd0, "dload_while_wait", dload[g], 32'd0);
        end
        if (iwait[g] === 1'b0) begin
          chk(iq[g].size() != 0, "i_unexpected_done", 32'(cyc), 32'd0);
          if (iq[g].size() != 0) begin
            e = iq[g].pop_front();
            chk(e.cyc == cyc, "i_done_cycle", 32'(cyc), 32'(e.cyc));
            chk(iload[g] === e.data, "iload", iload[g], e.data);
          end
        end else begin
          chk(iwait[g] === 1'b1 && iload[g] === 32'd0, "iload_while_wait", iload[g], 32'd0);
        end
      end
    end
  end

  // Completion offset after capture, straight from the timing rules.
  function automatic int off(input int k);
    return (k == 0) ? 1 : k + 2;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int k, input int n);
    dren[k] = 1'b0;
    dwen[k] = 1'b0;
    iren[k] = 1'b0;
    tick(n);
  endtask

  // cap: cycles until the controller is back in IDLE and can capture.
  task automatic d_req(input int k, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int cap);
    iren[k]   = 1'b0;
    dren[k]   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    dwen[k]   = wr;
    daddr[k]  = a;
    dstore[k] = wd;
    dq[k].push_back(exp_t'{cyc + cap + off(k), mm[k][widx(a)], !wr});
    if (wr) mm[k][widx(a)] = wd;
    tick(cap + off(k) + 1);
  endtask

  task automatic i_req(input int k, input logic [31:0] a);
    dren[k]  = 1'b0;
    dwen[k]  = 1'b0;
    iren[k]  = 1'b1;
    iaddr[k] = a;
    iq[k].push_back(exp_t'{cyc + off(k), mm[k][widx(a)], 1'b1});
    tick(off(k) + 1);
  endtask

  // Request changes index r cycles into the access: first one vanishes,
  // the second is captured in the following cycle.
  task automatic d_abort(input int k, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int r);
    iren[k]   = 1'b0;
    dren[k]   = !wr;
    dwen[k]   = wr;
    daddr[k]  = a;
    dstore[k] = wd;
    tick(r);
    d_req(k, wr, a + 32'd4, ~wd, 1);
  endtask

  task automatic arb(input int k, input logic [31:0] da, input logic [31:0] ia);
    dren[k]  = 1'b1;
    dwen[k]  = 1'b0;
    daddr[k] = da;
    iren[k]  = 1'b1;
    iaddr[k] = ia;
    dq[k].push_back(exp_t'{cyc + off(k), mm[k][widx(da)], 1'b1});
    iq[k].push_back(exp_t'{cyc + 2 * off(k) + 1, mm[k][widx(ia)], 1'b1});
    tick(off(k) + 1);
    dren[k] = 1'b0;
    tick(off(k) + 1);
  endtask

  initial begin
    logic [31:0] a, wd, ia;
    int op, nd;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; dren[k] = 1'b0; dwen[k] = 1'b0; iren[k] = 1'b0;
      daddr[k] = '0; dstore[k] = '0; iaddr[k] = '0;
    end
    tick(3);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    tick(1);
    for (int k = 0; k < NI; k++) begin
      chk(dwait[k] === 1'b1 && iwait[k] === 1'b1, "reset_wait", {dwait[k], iwait[k]}, 32'd3);
      chk(dload[k] === 32'd0 && iload[k] === 32'd0, "reset_load", dload[k] | iload[k], 32'd0);
    end

    // single read, LAT=2
    g_dut[2].u_dut.mem[5] = 32'hDEAD_BEEF;
    mm[2][5] = 32'hDEAD_BEEF;
    d_req(2, 1'b0, 32'h14, 32'd0, 0);
    idle(2, 2);
    // block fill: second word captured in the IDLE cycle
    d_req(2, 1'b0, 32'h40, 32'd0, 0);
    d_req(2, 1'b0, 32'h44, 32'd0, 0);
    idle(2, 2);
    // write then read, LAT=1
    d_req(1, 1'b1, 32'h8, 32'h1234_5678, 0);
    d_req(1, 1'b0, 32'h8, 32'd0, 0);
    idle(1, 2);
    chk(g_dut[1].u_dut.mem[2] === 32'h1234_5678, "wr_mem2", g_dut[1].u_dut.mem[2], 32'h1234_5678);
    // arbitration, LAT=2
    arb(2, 32'h100, 32'h200);
    idle(2, 2);
    // abort with upper-bit wrap, LAT=3
    dwen[3] = 1'b1; daddr[3] = 32'h1000_0010; dstore[3] = ~mm[3][4];
    tick(2);
    idle(3, 6);
    chk(g_dut[3].u_dut.mem[4] === mm[3][4], "abort_mem4", g_dut[3].u_dut.mem[4], mm[3][4]);
    d_req(3, 1'b0, 32'h10, 32'd0, 0);
    idle(3, 2);
    // reset mid-write, LAT=3
    dwen[3] = 1'b1; daddr[3] = 32'h1C; dstore[3] = ~mm[3][7];
    tick(2);
    rst[3] = 1'b1; dwen[3] = 1'b0;
    tick(1);
    rst[3] = 1'b0;
    chk(dwait[3] === 1'b1 && dload[3] === 32'd0, "rst_outputs", dload[3], 32'd0);
    tick(6);
    chk(g_dut[3].u_dut.mem[7] === mm[3][7], "rst_mem7", g_dut[3].u_dut.mem[7], mm[3][7]);
    // LAT=0
    d_req(0, 1'b0, 32'h30, 32'd0, 0);
    idle(0, 2);

    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 40; n++) begin
        a  = $urandom;
        wd = $urandom;
        ia = $urandom;
        op = $urandom_range(0, 5);
        case (op)
          0, 1:    d_req(k, 1'b0, a, 32'd0, 0);
          2:       d_req(k, 1'b1, a, wd, 0);
          3:       i_req(k, a);
          4:       d_abort(k, 1'($urandom_range(0, 1)), a, wd, $urandom_range(1, off(k)));
          default: arb(k, a, ia);
        endcase
        if ($urandom_range(0, 1) == 1) idle(k, $urandom_range(1, 2));
      end
      idle(k, 2);
    end

    tick(5);
    for (int k = 0; k < NI; k++) begin
      chk(dq[k].size() == 0, "d_queue_drained", 32'(dq[k].size()), 32'd0);
      chk(iq[k].size() == 0, "i_queue_drained", 32'(iq[k].size()), 32'd0);
    end
    nd = 0;
    for (int a2 = 0; a2 < 1024; a2++) if (g_dut[0].u_dut.mem[a2] !== mm[0][a2]) nd++;
    chk(nd == 0, "store0", 32'(nd), 32'd0);
    nd = 0;
    for (int a2 = 0; a2 < 1024; a2++) if (g_dut[1].u_dut.mem[a2] !== mm[1][a2]) nd++;
    chk(nd == 0, "store1", 32'(nd), 32'd0);
    nd = 0;
    for (int a2 = 0; a2 < 1024; a2++) if (g_dut[2].u_dut.mem[a2] !== mm[2][a2]) nd++;
    chk(nd == 0, "store2", 32'(nd), 32'd0);
    nd = 0;
    for (int a2 = 0; a2 < 1024; a2++) if (g_dut[3].u_dut.mem[a2] !== mm[3][a2]) nd++;
    chk(nd == 0, "store3", 32'(nd), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
